uart_tx_arbiter: RTL and testbench

Two-source round-robin scheduler that shares one `uart_rtscts` transmitter between two byte FIFOs. It sits between the FIFOs' output side (`data_o`, `status[0]`, `clk_o`) and the UART's `tx_data`/`tx_rdy`/`tx_pop` handshake, so two producers can time-share one serial line. Each grant lasts up to BURST bytes. An optional channel-header byte marks every change of source on the wire.

---
 rtl/uart_tx_arbiter.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler that lets two byte FIFOs share one uart_rtscts
// transmitter. A grant lasts up to BURST bytes while the other source is
// waiting. When the other source is idle, the current source keeps the line
// indefinitely.
//
// Optional feature (compile-time macro UART_ARB_HDR_EN):
//   defined   -> a header byte 0xF0|ch is sent before the first byte after
//                reset and before every byte that follows a change of source.
//   undefined -> the raw byte streams are interleaved with no markers.
//
// Parameters:
//   BURST      bytes per grant while the other source waits (1..255)
//
// Ports:
//   clk        block clock, shared with the UART
//   rst        asynchronous active-high reset
//   src_rdy    per-source FIFO not-empty
//   src_data0  source 0 FIFO head byte
//   src_data1  source 1 FIFO head byte
//   src_pop    per-source one-cycle pop pulse (registered)
//   tx_data    byte presented to the UART
//   tx_rdy     tx_data valid
//   tx_pop     UART has taken tx_data (one-cycle pulse)
//   cur_ch     currently granted source
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int unsigned BURST = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] src_rdy,
   input  logic [7:0] src_data0,
   input  logic [7:0] src_data1,
   output logic [1:0] src_pop,
   output logic [7:0] tx_data,
   output logic       tx_rdy,
   input  logic       tx_pop,
   output logic       cur_ch,
   output logic       busy
);

`ifdef UART_ARB_HDR_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   localparam logic [7:0] BURST_LIM = 8'(BURST);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_POP
   } state_e;

   state_e     state_q;
   logic       cur_ch_q;
   logic       last_ch_q;
   logic       last_vld_q;
   logic [7:0] burst_cnt_q;
   logic [1:0] src_pop_q;

   // Grant decision evaluated while in IDLE.
   logic grant;
   logic nxt_ch_d;
   logic clr_cnt;
   logic hdr_need;

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      grant    = 1'b0;
      nxt_ch_d = cur_ch_q;
      clr_cnt  = 1'b0;
      if ((burst_cnt_q < BURST_LIM) && src_rdy[cur_ch_q]) begin
         grant = 1'b1;
      end else if (src_rdy[~cur_ch_q]) begin
         grant    = 1'b1;
         nxt_ch_d = ~cur_ch_q;
         clr_cnt  = 1'b1;
      end else if (src_rdy[cur_ch_q]) begin
         // Burst used up but nobody is competing: restart the burst on the
         // same source. Source is unchanged, so no header follows.
         grant   = 1'b1;
         clr_cnt = 1'b1;
      end
      hdr_need = HDR_EN && (!last_vld_q || (last_ch_q != nxt_ch_d));
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cur_ch_q    <= 1'b0;
         last_ch_q   <= 1'b0;
         last_vld_q  <= 1'b0;
         burst_cnt_q <= 8'd0;
         src_pop_q   <= 2'b00;
      end else begin
         src_pop_q <= 2'b00;
         case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  cur_ch_q <= nxt_ch_d;
                  if (clr_cnt) begin
                     burst_cnt_q <= 8'd0;
                  end
                  state_q <= hdr_need ? ST_HDR : ST_DATA;
               end
            end
`ifdef UART_ARB_HDR_EN
            ST_HDR: begin
               if (tx_pop) begin
                  last_ch_q  <= cur_ch_q;
                  last_vld_q <= 1'b1;
                  state_q    <= ST_DATA;
               end
            end
`endif
            ST_DATA: begin
               // Losing src_rdy wins over tx_pop: tx_rdy is already low then,
               // so the UART cannot have taken the byte.
               if (!src_rdy[cur_ch_q]) begin
                  state_q <= ST_IDLE;
               end else if (tx_pop) begin
                  state_q   <= ST_POP;
                  src_pop_q <= cur_ch_q ? 2'b10 : 2'b01;
                  if (!HDR_EN) begin
                     last_ch_q  <= cur_ch_q;
                     last_vld_q <= 1'b1;
                  end
               end
            end
            ST_POP: begin
               if (burst_cnt_q != 8'hFF) begin
                  burst_cnt_q <= burst_cnt_q + 8'd1;
               end
               // IDLE re-samples src_rdy one cycle after the FIFO pop edge.
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // tx_rdy/tx_data follow src_rdy combinationally in DATA so a FIFO that
   // empties withdraws the byte in the same cycle.
   always_comb begin
      tx_rdy  = 1'b0;
      tx_data = 8'h00;
      case (state_q)
`ifdef UART_ARB_HDR_EN
         ST_HDR: begin
            tx_rdy  = 1'b1;
            tx_data = {7'b1111_000, cur_ch_q};
         end
`endif
         ST_DATA: begin
            tx_rdy  = src_rdy[cur_ch_q];
            tx_data = cur_ch_q ? src_data1 : src_data0;
         end
         default: ;
      endcase
   end

   assign src_pop = src_pop_q;
   assign cur_ch  = cur_ch_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int BURST = 2;

`ifdef UART_ARB_HDR_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] src_rdy;
   logic [7:0] src_data0;
   logic [7:0] src_data1;
   logic [1:0] src_pop;
   logic [7:0] tx_data;
   logic       tx_rdy;
   logic       tx_pop;
   logic       cur_ch;
   logic       busy;

   uart_tx_arbiter #(.BURST(BURST)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_rdy   (src_rdy),
      .src_data0 (src_data0),
      .src_data1 (src_data1),
      .src_pop   (src_pop),
      .tx_data   (tx_data),
      .tx_rdy    (tx_rdy),
      .tx_pop    (tx_pop),
      .cur_ch    (cur_ch),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] fifo0[$];
   logic [7:0] fifo1[$];
   logic [7:0] exp_q[$];
   int  pops0;
   int  pops1;
   bit  uart_en;
   bit  hide0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void update_src();
      src_rdy[0] = (fifo0.size() != 0) && !hide0;
      src_rdy[1] = (fifo1.size() != 0);
      src_data0  = (fifo0.size() != 0) ? fifo0[0] : 8'h00;
      src_data1  = (fifo1.size() != 0) ? fifo1[0] : 8'h00;
   endfunction

   // One clock of the environment, evaluated at the falling edge: UART side
   // (scoreboard compare and tx_pop pulse) then FIFO side (pop on src_pop).
   task automatic step();
      logic [7:0] exp_b;
      logic [1:0] exp_pop;
      @(negedge clk);
      if (uart_en) begin
         if (tx_pop) begin
            tx_pop = 1'b0;
         end else if (tx_rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL wire_byte: got %02h, expected no byte", tx_data);
            end else begin
               exp_b = exp_q.pop_front();
               if (tx_data !== exp_b) begin
                  failures++;
                  $display("FAIL wire_byte: got %02h, expected %02h", tx_data, exp_b);
               end
            end
            tx_pop = 1'b1;
         end
      end
      if (src_pop != 2'b00) begin
         exp_pop = cur_ch ? 2'b10 : 2'b01;
         checks++;
         if (src_pop !== exp_pop) begin
            failures++;
            $display("FAIL src_pop_onehot: got %b, expected %b", src_pop, exp_pop);
         end
         if (src_pop[0]) begin
            if (fifo0.size() == 0) begin
               failures++;
               $display("FAIL fifo0_underflow: got pop, expected none");
            end else void'(fifo0.pop_front());
            pops0++;
         end
         if (src_pop[1]) begin
            if (fifo1.size() == 0) begin
               failures++;
               $display("FAIL fifo1_underflow: got pop, expected none");
            end else void'(fifo1.pop_front());
            pops1++;
         end
      end
      update_src();
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      tx_pop  = 1'b0;
      uart_en = 1'b0;
      hide0   = 1'b0;
      fifo0.delete();
      fifo1.delete();
      exp_q.delete();
      pops0 = 0;
      pops1 = 0;
      update_src();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic run_until_drained(input string name, input int budget);
      int n = 0;
      uart_en = 1'b1;
      while ((exp_q.size() != 0 || busy || tx_pop || src_rdy != 2'b00) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || busy) begin
         failures++;
         $display("FAIL %s_timeout: got %0d bytes outstanding after %0d cycles, expected 0",
                  name, exp_q.size(), n);
      end
      uart_en = 1'b0;
   endtask

   // Manually take the header (if compiled in) so the DUT sits in DATA.
   task automatic take_header(input string name, input logic [7:0] hdr);
      step();
      if (HDR) begin
         checks++;
         if (tx_rdy !== 1'b1 || tx_data !== hdr) begin
            failures++;
            $display("FAIL %s_hdr: got rdy=%b data=%02h, expected rdy=1 data=%02h",
                     name, tx_rdy, tx_data, hdr);
         end
         tx_pop = 1'b1;
         step();
         tx_pop = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if ({tx_rdy, tx_data, src_pop, cur_ch, busy} !== 13'd0) begin
         failures++;
         $display("FAIL reset_values: got rdy=%b data=%02h pop=%b ch=%b busy=%b, expected all 0",
                  tx_rdy, tx_data, src_pop, cur_ch, busy);
      end
      do_reset();
   endtask

   task automatic test_single_source();
      do_reset();
      fifo0 = '{8'h11, 8'h22, 8'h33};
      if (HDR) exp_q.push_back(8'hF0);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      update_src();
      run_until_drained("single", 200);
      checks++;
      if (pops0 != 3 || pops1 != 0) begin
         failures++;
         $display("FAIL single_pops: got pop0=%0d pop1=%0d, expected 3 0", pops0, pops1);
      end
   endtask

   task automatic test_interleave();
      logic [7:0] hdr_seq[$];
      do_reset();
      fifo0 = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
      fifo1 = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
      if (HDR)
         hdr_seq = '{8'hF0, 8'hA0, 8'hA1, 8'hF1, 8'hB0, 8'hB1,
                     8'hF0, 8'hA2, 8'hA3, 8'hF1, 8'hB2, 8'hB3};
      else
         hdr_seq = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3};
      exp_q = hdr_seq;
      update_src();
      run_until_drained("interleave", 400);
      checks++;
      if (pops0 != 4 || pops1 != 4) begin
         failures++;
         $display("FAIL interleave_pops: got pop0=%0d pop1=%0d, expected 4 4", pops0, pops1);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      fifo1 = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
      if (HDR) exp_q.push_back(8'hF1);
      for (int i = 0; i < 5; i++) exp_q.push_back(8'hC0 + 8'(i));
      update_src();
      run_until_drained("back_to_back", 300);
      checks++;
      if (pops1 != 5 || pops0 != 0 || cur_ch !== 1'b1) begin
         failures++;
         $display("FAIL back_to_back_pops: got pop0=%0d pop1=%0d ch=%b, expected 0 5 1",
                  pops0, pops1, cur_ch);
      end
   endtask

   task automatic test_ignored_pop();
      do_reset();
      tx_pop = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || src_pop !== 2'b00 || tx_rdy !== 1'b0) begin
         failures++;
         $display("FAIL idle_pop: got busy=%b pop=%b rdy=%b, expected 0 00 0", busy, src_pop, tx_rdy);
      end
      tx_pop = 1'b0;
      fifo0.push_back(8'h5A);
      update_src();
      take_header("ignpop", 8'hF0);
      checks++;
      if (tx_rdy !== 1'b1 || tx_data !== 8'h5A) begin
         failures++;
         $display("FAIL ignpop_data: got rdy=%b data=%02h, expected 1 5a", tx_rdy, tx_data);
      end
      tx_pop = 1'b1;
      step();
      checks++;
      if (src_pop !== 2'b01 || tx_rdy !== 1'b0) begin
         failures++;
         $display("FAIL pop_pulse: got pop=%b rdy=%b, expected 01 0", src_pop, tx_rdy);
      end
      step();  // tx_pop still high through the POP cycle
      checks++;
      if (src_pop !== 2'b00 || tx_rdy !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL pop_in_pop: got pop=%b rdy=%b busy=%b, expected 00 0 0",
                  src_pop, tx_rdy, busy);
      end
      tx_pop = 1'b0;
      step();
      checks++;
      if (pops0 != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL ignpop_count: got pops0=%0d busy=%b, expected 1 0", pops0, busy);
      end
   endtask

   task automatic test_drop_rdy();
      do_reset();
      fifo0.push_back(8'h77);
      update_src();
      take_header("drop", 8'hF0);
      checks++;
      if (tx_rdy !== 1'b1 || tx_data !== 8'h77) begin
         failures++;
         $display("FAIL drop_data: got rdy=%b data=%02h, expected 1 77", tx_rdy, tx_data);
      end
      hide0 = 1'b1;
      update_src();
      #1;
      checks++;
      if (tx_rdy !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL drop_same_cycle: got rdy=%b busy=%b, expected 0 1", tx_rdy, busy);
      end
      step();
      checks++;
      if (busy !== 1'b0 || src_pop !== 2'b00) begin
         failures++;
         $display("FAIL drop_to_idle: got busy=%b pop=%b, expected 0 00", busy, src_pop);
      end
      hide0 = 1'b0;
      update_src();
      exp_q.push_back(8'h77);
      run_until_drained("drop", 100);
      checks++;
      if (pops0 != 1) begin
         failures++;
         $display("FAIL drop_pops: got %0d, expected 1", pops0);
      end
   endtask

   task automatic test_reset_in_pop();
      do_reset();
      fifo0 = '{8'h99, 8'hAA};
      update_src();
      take_header("rstpop", 8'hF0);
      checks++;
      if (tx_data !== 8'h99) begin
         failures++;
         $display("FAIL rstpop_data: got %02h, expected 99", tx_data);
      end
      tx_pop = 1'b1;
      rst    = 1'b1;
      step();
      checks++;
      if (src_pop !== 2'b00 || busy !== 1'b0 || tx_rdy !== 1'b0 || tx_data !== 8'h00 ||
          fifo0.size() != 2 || pops0 != 0) begin
         failures++;
         $display("FAIL rstpop_nopop: got pop=%b busy=%b rdy=%b data=%02h fifo=%0d, expected 00 0 0 00 2",
                  src_pop, busy, tx_rdy, tx_data, fifo0.size());
      end
      rst    = 1'b0;
      tx_pop = 1'b0;
      if (HDR) exp_q.push_back(8'hF0);
      exp_q.push_back(8'h99);
      exp_q.push_back(8'hAA);
      run_until_drained("rstpop", 200);
      checks++;
      if (pops0 != 2) begin
         failures++;
         $display("FAIL rstpop_pops: got %0d, expected 2", pops0);
      end
   endtask

   initial begin
      rst       = 1'b1;
      tx_pop    = 1'b0;
      src_rdy   = 2'b00;
      src_data0 = 8'h00;
      src_data1 = 8'h00;
      test_reset();
      test_single_source();
      test_interleave();
      test_back_to_back();
      test_ignored_pop();
      test_drop_rdy();
      test_reset_in_pop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
